// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row synchronisation, debounce and one-shot key codes.
// Optional nibble-to-byte assembly is enabled by defining KEYPAD_BYTE_ASSEMBLY_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  localparam int unsigned STEP_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t            state, state_d;
  logic [3:0]        fil_s1, fil_s2;
  logic [STEP_W-1:0] step_cnt;
  logic [1:0]        col_idx, col_idx_d;
  logic [1:0]        cand_row, cand_row_d;
  logic [DEB_W-1:0]  cnt, cnt_d;
  logic              sample, row_hit, accept;
  logic [1:0]        row_idx;
  logic [3:0]        accept_code;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign col         = ~(4'b0001 << col_idx);
  assign sample      = (step_cnt == STEP_W'(SCAN_DIV - 1));
  assign row_hit     = ~&fil_s2;
  assign accept_code = key_map(cand_row, col_idx);

  // Lowest low row wins when several rows share the active column.
  always_comb begin
    casez (fil_s2)
      4'b???0: row_idx = 2'd0;
      4'b??01: row_idx = 2'd1;
      4'b?011: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
  end

  always_comb begin
    state_d    = state;
    col_idx_d  = col_idx;
    cand_row_d = cand_row;
    cnt_d      = cnt;
    accept     = 1'b0;
    case (state)
      SCAN: if (sample) begin
        if (row_hit) begin
          cand_row_d = row_idx;
          cnt_d      = '0;
          state_d    = DEBOUNCE;
        end else begin
          col_idx_d = col_idx + 2'd1;
        end
      end
      // The detecting sample counts as the first match, so acceptance fires on the count itself.
      DEBOUNCE: if (cnt == DEB_W'(DEB_SCANS - 1)) begin
        state_d = PRESSED;
        accept  = 1'b1;
        cnt_d   = '0;
      end else if (sample) begin
        if (row_hit && row_idx == cand_row) cnt_d = cnt + 1'b1;
        else state_d = SCAN;
      end
      PRESSED: if (sample) begin
        if (row_hit) cnt_d = '0;
        else if (cnt == DEB_W'(DEB_SCANS - 1)) state_d = RELEASE;
        else cnt_d = cnt + 1'b1;
      end
      default: begin
        col_idx_d = col_idx + 2'd1;
        state_d   = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      fil_s1    <= 4'hF;
      fil_s2    <= 4'hF;
      step_cnt  <= '0;
      col_idx   <= '0;
      cand_row  <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      fil_s1    <= fil;
      fil_s2    <= fil_s1;
      step_cnt  <= sample ? '0 : step_cnt + 1'b1;
      col_idx   <= col_idx_d;
      cand_row  <= cand_row_d;
      cnt       <= cnt_d;
      key_valid <= accept;
      key_held  <= (state_d == PRESSED);
      if (accept) key_code <= accept_code;
    end
  end

`ifdef KEYPAD_BYTE_ASSEMBLY_EN
  logic       phase;
  logic [3:0] hi_nib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 1'b0;
      hi_nib     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (accept) begin
        if (!phase) begin
          hi_nib <= accept_code;
          phase  <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (accept_code != 4'hE) begin
            byte_out   <= {hi_nib, accept_code};
            byte_valid <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign byte_out   = '0;
  assign byte_valid = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-gated keypad model (SCAN_DIV=4, DEB_SCANS=2).
module tb_keypad_scanner;

`ifdef KEYPAD_BYTE_ASSEMBLY_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fil, col, key_code;
  logic       key_valid, key_held, byte_valid;
  logic [7:0] byte_out;
  logic [15:0] pressed = '0;

  int pass_cnt = 0, total_cnt = 0, valid_cnt = 0, byte_cnt = 0;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    string       name;
  } vec_t;
  vec_t vecs[19];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (
    .clk(clk), .rst(rst), .fil(fil), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .byte_out(byte_out), .byte_valid(byte_valid)
  );

  // A pressed key at (r,c) pulls row r low only while column c is strobed.
  always_comb begin
    fil = 4'hF;
    for (int r = 0; r < 4; r++)
      fil[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  always @(negedge clk) begin
    if (key_valid) valid_cnt++;
    if (byte_valid) byte_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tap(input logic [15:0] m);
    pressed = m;
    step(60);
    pressed = '0;
    step(40);
  endtask

  int v0, b0, n;
  logic [3:0] c0;

  initial begin
    vecs[0]  = '{16'h0001, 4'h1, "k1"};  vecs[1]  = '{16'h0002, 4'h2, "k2"};
    vecs[2]  = '{16'h0004, 4'h3, "k3"};  vecs[3]  = '{16'h0008, 4'hA, "kA"};
    vecs[4]  = '{16'h0010, 4'h4, "k4"};  vecs[5]  = '{16'h0020, 4'h5, "k5"};
    vecs[6]  = '{16'h0040, 4'h6, "k6"};  vecs[7]  = '{16'h0080, 4'hB, "kB"};
    vecs[8]  = '{16'h0100, 4'h7, "k7"};  vecs[9]  = '{16'h0200, 4'h8, "k8"};
    vecs[10] = '{16'h0400, 4'h9, "k9"};  vecs[11] = '{16'h0800, 4'hC, "kC"};
    vecs[12] = '{16'h1000, 4'hE, "kE"};  vecs[13] = '{16'h2000, 4'h0, "k0"};
    vecs[14] = '{16'h4000, 4'hF, "kF"};  vecs[15] = '{16'h8000, 4'hD, "kD"};
    vecs[16] = '{16'h1010, 4'h4, "multi_4E"};
    vecs[17] = '{16'h4400, 4'h9, "multi_9F"};
    vecs[18] = '{16'h8008, 4'hA, "multi_AD"};

    // T1 reset and free-running rotation
    rst = 1'b1;
    step(3);
    check("rst_col", 32'(col), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_byte", 32'(byte_out), 32'h0);
    check("rst_bvalid", 32'(byte_valid), 32'h0);
    rst = 1'b0;
    step(4); check("rot1", 32'(col), 32'hD);
    step(4); check("rot2", 32'(col), 32'hB);
    step(4); check("rot3", 32'(col), 32'h7);
    step(4); check("rot4", 32'(col), 32'hE);
    step(20);
    check("idle_no_valid", 32'(valid_cnt), 32'd0);

    // T2 single press of '5'
    v0 = valid_cnt;
    pressed = 16'h0020;
    step(60);
    check("t2_count", 32'(valid_cnt - v0), 32'd1);
    check("t2_code", 32'(key_code), 32'h5);
    check("t2_held", 32'(key_held), 32'd1);
    pressed = '0;
    step(2);
    check("t2_held_early", 32'(key_held), 32'd1);
    step(38);
    check("t2_held_off", 32'(key_held), 32'd0);
    check("t2_count_after", 32'(valid_cnt - v0), 32'd1);

    // T3 bounce on '9': start two cycles after a column wrap so that two
    // consecutive column samples never both see the key down.
    v0 = valid_cnt;
    c0 = col;
    n = 0;
    while (col == c0 && n < 10) begin step(1); n++; end
    check("t3_sync", 32'(col != c0), 32'd1);
    step(2);
    for (int j = 0; j < 30; j++) begin
      pressed = (((j / 3) % 2) == 0) ? 16'h0400 : 16'h0000;
      step(1);
    end
    pressed = 16'h0400;
    check("t3_no_valid_bounce", 32'(valid_cnt - v0), 32'd0);
    step(60);
    check("t3_count", 32'(valid_cnt - v0), 32'd1);
    check("t3_code", 32'(key_code), 32'h9);
    pressed = '0;
    step(40);

    // Key map and multi-row priority
    for (int i = 0; i < 19; i++) begin
      v0 = valid_cnt;
      pressed = vecs[i].mask;
      step(60);
      check({vecs[i].name, "_count"}, 32'(valid_cnt - v0), 32'd1);
      check({vecs[i].name, "_code"}, 32'(key_code), 32'(vecs[i].code));
      check({vecs[i].name, "_held"}, 32'(key_held), 32'd1);
      pressed = '0;
      step(40);
      check({vecs[i].name, "_rel"}, 32'(key_held), 32'd0);
      check({vecs[i].name, "_once"}, 32'(valid_cnt - v0), 32'd1);
    end

    // T4 rollover
    v0 = valid_cnt;
    pressed = 16'h0001;
    step(60);
    check("t4_first", 32'(key_code), 32'h1);
    pressed = 16'h0003;
    step(60);
    check("t4_roll_count", 32'(valid_cnt - v0), 32'd1);
    check("t4_roll_held", 32'(key_held), 32'd1);
    pressed = '0;
    step(40);
    check("t4_code_holds", 32'(key_code), 32'h1);
    check("t4_rel_count", 32'(valid_cnt - v0), 32'd1);
    pressed = 16'h0002;
    step(60);
    check("t4_second_count", 32'(valid_cnt - v0), 32'd2);
    check("t4_second_code", 32'(key_code), 32'h2);
    pressed = '0;
    step(40);

    // T5 reset during debounce of 'A'
    v0 = valid_cnt;
    n = 0;
    while (col == 4'b0111 && n < 20) begin step(1); n++; end
    n = 0;
    while (col != 4'b0111 && n < 20) begin step(1); n++; end
    check("t5_sync", 32'(col), 32'h7);
    pressed = 16'h0008;
    step(4);
    check("t5_frozen", 32'(col), 32'h7);
    step(2);
    rst = 1'b1;
    #1;
    check("t5_col", 32'(col), 32'hE);
    check("t5_code", 32'(key_code), 32'h0);
    check("t5_valid", 32'(key_valid), 32'h0);
    check("t5_held", 32'(key_held), 32'h0);
    step(3);
    pressed = '0;
    rst = 1'b0;
    step(40);
    check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);

    // T6 byte assembly: 4,5,0,7 then 3,E (abandoned) and 1,2
    b0 = byte_cnt;
    tap(16'h0010); tap(16'h0020);
    check("t6_byte1_count", 32'(byte_cnt - b0), MAC ? 32'd1 : 32'd0);
    check("t6_byte1", 32'(byte_out), MAC ? 32'h45 : 32'h0);
    tap(16'h2000); tap(16'h0100);
    check("t6_byte2_count", 32'(byte_cnt - b0), MAC ? 32'd2 : 32'd0);
    check("t6_byte2", 32'(byte_out), MAC ? 32'h07 : 32'h0);
    tap(16'h0004); tap(16'h1000);
    check("t6_e_clear_count", 32'(byte_cnt - b0), MAC ? 32'd2 : 32'd0);
    tap(16'h0001); tap(16'h0002);
    check("t6_byte3_count", 32'(byte_cnt - b0), MAC ? 32'd3 : 32'd0);
    check("t6_byte3", 32'(byte_out), MAC ? 32'h12 : 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
